polaris_bus_arbiter: RTL and testbench

Two-to-one bus arbiter for the Polaris CPU's separate instruction-fetch (I) and data (D) master ports. It merges both onto a single 64-bit memory master port for one shared memory or peripheral bus. Requests are registered at grant time. Ties are broken round-robin, with D taking the first tie after reset. It sits between the CPU core and the system interconnect.

---
 rtl/polaris_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_polaris_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polaris_bus_arbiter.sv
// Two-to-one arbiter merging the Polaris I-fetch and D ports onto one 64-bit master port.
// Optional grant timeout is compiled in with POLARIS_ARB_TMO_EN.
module polaris_bus_arbiter #(
    parameter int TMO_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic        dwe_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic [63:0] madr_o,
    output logic [63:0] mdat_o,
    output logic        mwe_o,
    output logic        mcyc_o,
    output logic        mstb_o,
    output logic [1:0]  msiz_o,
    output logic        msigned_o,
    input  logic        mack_i,
    input  logic [63:0] mdat_i,
    output logic        merr_o,
    output logic        gnt_d_o
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      r_state;
    logic        r_last_d;
    logic        w_ireq;
    logic        w_dreq;
    logic        w_pick_d;
    logic        w_gnt;
    logic        w_tmo;
    logic        w_done;
    logic [63:0] w_rdata;

    assign w_ireq   = (isiz_i != 2'b00);
    assign w_dreq   = dcyc_i & dstb_i;
    assign w_pick_d = w_dreq & (~w_ireq | ~r_last_d);
    assign w_gnt    = (r_state != IDLE);

`ifdef POLARIS_ARB_TMO_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    logic [7:0] r_tmo_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tmo_cnt <= 8'd0;
        end else if (!w_gnt) begin
            r_tmo_cnt <= 8'd0;
        end else if (!mack_i) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo = w_gnt & ~mack_i & (r_tmo_cnt == TMO_LAST);
`else
    // TMO_CYCLES has no effect without the timeout
    assign w_tmo = 1'b0 & (TMO_CYCLES > 0);
`endif

    assign w_done = w_gnt & (mack_i | w_tmo);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            madr_o    <= 64'd0;
            mdat_o    <= 64'd0;
            mwe_o     <= 1'b0;
            mcyc_o    <= 1'b0;
            mstb_o    <= 1'b0;
            msiz_o    <= 2'b00;
            msigned_o <= 1'b0;
            gnt_d_o   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ireq | w_dreq) begin
                        r_last_d <= w_pick_d;
                        mcyc_o   <= 1'b1;
                        mstb_o   <= 1'b1;
                        if (w_pick_d) begin
                            r_state   <= GNT_D;
                            gnt_d_o   <= 1'b1;
                            madr_o    <= dadr_i;
                            mdat_o    <= ddat_i;
                            mwe_o     <= dwe_i;
                            msiz_o    <= dsiz_i;
                            msigned_o <= dsigned_i;
                        end else begin
                            r_state   <= GNT_I;
                            gnt_d_o   <= 1'b0;
                            madr_o    <= iadr_i;
                            mdat_o    <= 64'd0;
                            mwe_o     <= 1'b0;
                            msiz_o    <= isiz_i;
                            msigned_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    // address/data registers deliberately hold after completion
                    if (w_done) begin
                        r_state <= IDLE;
                        mcyc_o  <= 1'b0;
                        mstb_o  <= 1'b0;
                        gnt_d_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign iack_o  = (r_state == GNT_I) & w_done;
    assign dack_o  = (r_state == GNT_D) & w_done;
    assign merr_o  = w_tmo;
    assign w_rdata = w_tmo ? 64'd0 : mdat_i;
    assign ddat_o  = dack_o ? w_rdata : 64'd0;
    assign idat_o  = iack_o ? (madr_o[2] ? w_rdata[63:32] : w_rdata[31:0]) : 32'd0;

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Bench for polaris_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level owner model (POLARIS_ARB_TMO_EN aware).
module tb_polaris_bus_arbiter;

`ifdef POLARIS_ARB_TMO_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 64;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic        dwe_i;
    logic        dcyc_i;
    logic        dstb_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] madr_o;
    logic [63:0] mdat_o;
    logic        mwe_o;
    logic        mcyc_o;
    logic        mstb_o;
    logic [1:0]  msiz_o;
    logic        msigned_o;
    logic        mack_i;
    logic [63:0] mdat_i;
    logic        merr_o;
    logic        gnt_d_o;

    polaris_bus_arbiter #(.TMO_CYCLES(TB_TMO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
        .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
        .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
        .dack_o(dack_o), .ddat_o(ddat_o),
        .madr_o(madr_o), .mdat_o(mdat_o), .mwe_o(mwe_o), .mcyc_o(mcyc_o),
        .mstb_o(mstb_o), .msiz_o(msiz_o), .msigned_o(msigned_o),
        .mack_i(mack_i), .mdat_i(mdat_i), .merr_o(merr_o), .gnt_d_o(gnt_d_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic clr_in();
        iadr_i = '0; isiz_i = '0; dadr_i = '0; ddat_i = '0; dwe_i = 0;
        dcyc_i = 0; dstb_i = 0; dsiz_i = '0; dsigned_i = 0; mack_i = 0; mdat_i = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clr_in();
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    typedef struct {
        logic ireq, dreq, mack;
        logic e_mcyc, e_gnt_d, e_iack, e_dack;
    } vec_t;

    vec_t vt[17];

    // transaction-level reference: who owns the bus and what it latched
    int          m_own;
    bit          m_last_d;
    logic [63:0] m_adr, m_dat;
    logic        m_we, m_sgn;
    logic [1:0]  m_siz;
    int          m_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dack_cnt, iack_cnt, gd_seen;
        logic [2:0] gd_hist;
        bit i_act, i_drop, d_act, d_drop;
        logic e_tmo, e_hit, e_iack, e_dack;

        vt[0]  = '{0,0,0, 0,0,0,0};
        vt[1]  = '{1,1,0, 0,0,0,0};
        vt[2]  = '{1,1,1, 1,1,0,1};
        vt[3]  = '{1,0,0, 0,0,0,0};
        vt[4]  = '{1,0,0, 1,0,0,0};
        vt[5]  = '{1,1,1, 1,0,1,0};
        vt[6]  = '{0,1,1, 0,0,0,0};
        vt[7]  = '{0,1,0, 1,1,0,0};
        vt[8]  = '{0,1,1, 1,1,0,1};
        vt[9]  = '{0,0,0, 0,0,0,0};
        vt[10] = '{1,1,0, 0,0,0,0};
        vt[11] = '{1,1,1, 1,0,1,0};
        vt[12] = '{0,1,0, 0,0,0,0};
        vt[13] = '{0,1,0, 1,1,0,0};
        vt[14] = '{0,0,0, 1,1,0,0};
        vt[15] = '{0,0,1, 1,1,0,1};
        vt[16] = '{0,0,0, 0,0,0,0};

        // reset values
        reset_i = 1'b1;
        clr_in();
        #3;
        chk("rst_madr", madr_o, 0);
        chk("rst_mcyc", {mcyc_o, mstb_o, mwe_o, msigned_o}, 0);
        chk("rst_acks", {iack_o, dack_o, merr_o, gnt_d_o}, 0);
        chk("rst_data", {idat_o, 32'd0} | ddat_o | mdat_o | {62'd0, msiz_o}, 0);
        do_reset();

        // vector table: one row per cycle
        for (int r = 0; r < 17; r++) begin
            isiz_i = vt[r].ireq ? 2'd1 : 2'd0;
            dcyc_i = vt[r].dreq; dstb_i = vt[r].dreq;
            mack_i = vt[r].mack;
            mdat_i = 64'h1111_2222_3333_4444 + 64'(r);
            smp();
            chk($sformatf("vec%0d_mcyc", r), mcyc_o, vt[r].e_mcyc);
            chk($sformatf("vec%0d_gnt_d", r), gnt_d_o, vt[r].e_gnt_d);
            chk($sformatf("vec%0d_iack", r), iack_o, vt[r].e_iack);
            chk($sformatf("vec%0d_dack", r), dack_o, vt[r].e_dack);
            cyc();
        end

        // zero-wait I fetch of the upper word
        clr_in();
        do_reset();
        iadr_i = 64'h1004; isiz_i = 2'd2;
        cyc();
        mack_i = 1; mdat_i = 64'hAAAA_BBBB_CCCC_DDDD;
        smp();
        chk("ifetch_iack", iack_o, 1);
        chk("ifetch_idat", idat_o, 64'hAAAA_BBBB);
        chk("ifetch_madr", madr_o, 64'h1004);
        chk("ifetch_mwe_mdat", {mwe_o, msigned_o} | mdat_o, 0);
        chk("ifetch_msiz", msiz_o, 2);
        chk("ifetch_dack", dack_o, 0);
        cyc();
        clr_in();
        smp();
        chk("ifetch_idle", {mcyc_o, iack_o, 30'd0} | idat_o, 0);

        // store with three wait states
        dadr_i = 64'h2000; ddat_i = 64'h55; dsiz_i = 2'd3; dwe_i = 1; dsigned_i = 1;
        dcyc_i = 1; dstb_i = 1;
        cyc();
        dack_cnt = 0; iack_cnt = 0;
        for (int g = 1; g <= 4; g++) begin
            mack_i = (g == 4);
            smp();
            chk($sformatf("st%0d_madr", g), madr_o, 64'h2000);
            chk($sformatf("st%0d_mdat", g), mdat_o, 64'h55);
            chk($sformatf("st%0d_mwe_cyc_sgn", g), {mwe_o, mcyc_o, mstb_o, msigned_o, msiz_o}, 6'b111111);
            dack_cnt += int'(dack_o);
            iack_cnt += int'(iack_o);
            cyc();
        end
        clr_in();
        smp();
        chk("st_dack_pulses", dack_cnt, 1);
        chk("st_iack_none", iack_cnt, 0);
        chk("st_done_idle", {mcyc_o, mstb_o, dack_o}, 0);
        chk("st_madr_hold", madr_o, 64'h2000);

        // both requesters held: D, I, D
        do_reset();
        isiz_i = 2'd1; dcyc_i = 1; dstb_i = 1; mack_i = 1;
        gd_seen = 0; gd_hist = '0;
        for (int c = 0; c < 8; c++) begin
            smp();
            if (mcyc_o && gd_seen < 3) begin
                gd_hist[gd_seen] = gnt_d_o;
                gd_seen++;
            end
            cyc();
        end
        chk("rr_grants_seen", gd_seen, 3);
        chk("rr_gnt_d_seq", gd_hist, 3'b101);
        clr_in();

        // reset in the middle of a D wait
        do_reset();
        dcyc_i = 1; dstb_i = 1; dadr_i = 64'h3000;
        cyc();
        smp();
        chk("rstmid_granted", {mcyc_o, gnt_d_o}, 2'b11);
        mack_i = 1;
        #2 reset_i = 1'b1;
        #1;
        chk("rstmid_async", {mcyc_o, mstb_o, dack_o, iack_o, merr_o, gnt_d_o}, 0);
        cyc();
        clr_in();
        reset_i = 1'b0;
        smp();
        chk("rstmid_idle", {mcyc_o, gnt_d_o, dack_o}, 0);
        cyc();
        mack_i = 1;
        smp();
        chk("rstmid_no_ack", {mcyc_o, dack_o, iack_o}, 0);
        cyc();
        clr_in();

`ifdef POLARIS_ARB_TMO_EN
        // slave never acks: abort on the 4th grant cycle
        do_reset();
        dcyc_i = 1; dstb_i = 1; dadr_i = 64'h4000; mdat_i = 64'hDEAD_BEEF_0BAD_F00D;
        cyc();
        for (int g = 1; g <= 4; g++) begin
            smp();
            if (g < 4) begin
                chk($sformatf("tmo_wait%0d", g), {dack_o, merr_o, mcyc_o}, 3'b001);
            end else begin
                chk("tmo_abort", {dack_o, merr_o}, 2'b11);
                chk("tmo_ddat_zero", ddat_o, 0);
            end
            cyc();
        end
        dcyc_i = 0; dstb_i = 0;
        smp();
        chk("tmo_idle", {mcyc_o, gnt_d_o, merr_o, dack_o}, 0);
        cyc();
        // real ack in the 4th grant cycle wins
        dcyc_i = 1; dstb_i = 1;
        cyc();
        for (int g = 1; g <= 4; g++) begin
            mack_i = (g == 4);
            smp();
            if (g == 4) begin
                chk("tmo_race_ack", {dack_o, merr_o}, 2'b10);
                chk("tmo_race_ddat", ddat_o, 64'hDEAD_BEEF_0BAD_F00D);
            end
            cyc();
        end
        clr_in();
        smp();
        chk("tmo_race_idle", mcyc_o, 0);
`endif

        // randomized traffic against the owner model
        do_reset();
        m_own = 0; m_last_d = 0; m_adr = '0; m_dat = '0; m_we = 0; m_sgn = 0; m_siz = '0; m_cnt = 0;
        i_act = 0; i_drop = 0; d_act = 0; d_drop = 0;
        for (int c = 0; c < 3000; c++) begin
            if (i_drop) begin
                i_act = 0; i_drop = 0; isiz_i = 2'd0;
            end else if (!i_act && ($urandom % 3 == 0)) begin
                i_act = 1;
                iadr_i = {$urandom, $urandom};
                isiz_i = 2'($urandom_range(1, 3));
            end
            if (d_drop) begin
                d_act = 0; d_drop = 0; dstb_i = 0; dcyc_i = $urandom % 2;
            end else if (!d_act && ($urandom % 3 == 0)) begin
                d_act = 1;
                dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
                dwe_i = $urandom % 2; dsiz_i = 2'($urandom); dsigned_i = $urandom % 2;
                dcyc_i = 1; dstb_i = 1;
            end else if (!d_act) begin
                dcyc_i = $urandom % 2; dstb_i = 0;
            end
            mack_i = ($urandom % 3 == 0);
            mdat_i = {$urandom, $urandom};
            smp();

            e_tmo  = (m_own != 0) && !mack_i && (TB_TMO - 1 == m_cnt);
`ifndef POLARIS_ARB_TMO_EN
            e_tmo  = 1'b0;
`endif
            e_hit  = (m_own != 0) && (mack_i || e_tmo);
            e_iack = (m_own == 1) && e_hit;
            e_dack = (m_own == 2) && e_hit;
            chk("rnd_mcyc_mstb", {mcyc_o, mstb_o}, {2{m_own != 0}});
            chk("rnd_gnt_d", gnt_d_o, m_own == 2);
            chk("rnd_madr", madr_o, m_adr);
            chk("rnd_mdat", mdat_o, m_dat);
            chk("rnd_we_sgn_siz", {mwe_o, msigned_o, msiz_o}, {m_we, m_sgn, m_siz});
            chk("rnd_acks", {iack_o, dack_o, merr_o}, {e_iack, e_dack, e_tmo});
            chk("rnd_ddat", ddat_o, (e_dack && !e_tmo) ? mdat_i : 64'd0);
            chk("rnd_idat", idat_o, (e_iack && !e_tmo) ? (m_adr[2] ? mdat_i[63:32] : mdat_i[31:0]) : 64'd0);

            if (e_iack) i_drop = 1;
            if (e_dack) d_drop = 1;
            if (m_own == 0) begin
                m_cnt = 0;
                if (dcyc_i && dstb_i && (isiz_i == 0 || !m_last_d)) begin
                    m_own = 2; m_last_d = 1;
                    m_adr = dadr_i; m_dat = ddat_i; m_we = dwe_i; m_sgn = dsigned_i; m_siz = dsiz_i;
                end else if (isiz_i != 0) begin
                    m_own = 1; m_last_d = 0;
                    m_adr = iadr_i; m_dat = 0; m_we = 0; m_sgn = 0; m_siz = isiz_i;
                end
            end else if (e_hit) begin
                m_own = 0;
            end else begin
                m_cnt++;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
